// File: rtl/formula_enum_sequencer.sv
// Exhaustive checker: enumerates the low K formula inputs over a fixed base vector and reports falsifying assignments.
// Optional macro FORMULA_ENUM_ALL_CEX_EN: report every counterexample and add the cex_cnt output.
module formula_enum_sequencer #(
  parameter int N_IN   = 49,
  parameter int K_MAX  = 16,
  parameter int SETTLE = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [$clog2(K_MAX+1)-1:0] k_sel,
  input  logic [N_IN-1:0]            base_vec,
  output logic [N_IN-1:0]            f_vec,
  input  logic                       f_out,
  output logic                       busy,
  output logic                       done,
  output logic                       valid_all,
  output logic                       cex_valid,
  input  logic                       cex_ready,
  output logic [N_IN-1:0]            cex_vec,
  output logic [K_MAX:0]             eval_cnt,
`ifdef FORMULA_ENUM_ALL_CEX_EN
  output logic [K_MAX:0]             cex_cnt,
`endif
  output logic [2:0]                 dbg_state
);

  localparam int KW = $clog2(K_MAX + 1);

  // Handshake: the counterexample transfers on a rising edge where cex_valid
  // and cex_ready are both high; cex_valid/cex_vec are stable until then.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_APPLY  = 3'd1,
    S_WAIT   = 3'd2,
    S_CHECK  = 3'd3,
    S_REPORT = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t            r_state;
  logic [K_MAX-1:0]  r_idx;
  logic [KW-1:0]     r_k;
  logic [N_IN-1:0]   r_base;
  logic [3:0]        r_settle;

  logic [N_IN-1:0]   w_apply;
  logic [K_MAX-1:0]  w_last_idx;
  logic              w_last;

  always_comb begin
    w_apply    = r_base;
    w_last_idx = '0;
    for (int i = 0; i < K_MAX; i++) begin
      if (i < int'(r_k)) begin
        w_apply[i]    = r_idx[i];
        w_last_idx[i] = 1'b1;
      end
    end
  end

  assign w_last    = (r_idx == w_last_idx);
  assign dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_k       <= '0;
      r_base    <= '0;
      r_settle  <= '0;
      f_vec     <= '0;
      cex_vec   <= '0;
      eval_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      valid_all <= 1'b0;
      cex_valid <= 1'b0;
`ifdef FORMULA_ENUM_ALL_CEX_EN
      cex_cnt   <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_base    <= base_vec;
            r_k       <= (k_sel > KW'(K_MAX)) ? KW'(K_MAX) : k_sel;
            r_idx     <= '0;
            eval_cnt  <= '0;
            valid_all <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b1;
`ifdef FORMULA_ENUM_ALL_CEX_EN
            cex_cnt   <= '0;
`endif
            r_state   <= S_APPLY;
          end
        end
        S_APPLY: begin
          f_vec    <= w_apply;
          r_settle <= 4'(SETTLE);
          r_state  <= (SETTLE > 0) ? S_WAIT : S_CHECK;
        end
        S_WAIT: begin
          r_settle <= r_settle - 4'd1;
          if (r_settle == 4'd1) r_state <= S_CHECK;
        end
        S_CHECK: begin
          eval_cnt <= eval_cnt + 1'b1;
          if (!f_out) begin
            cex_vec   <= f_vec;
            cex_valid <= 1'b1;
`ifdef FORMULA_ENUM_ALL_CEX_EN
            cex_cnt   <= cex_cnt + 1'b1;
`endif
            r_state   <= S_REPORT;
          end else if (w_last) begin
`ifdef FORMULA_ENUM_ALL_CEX_EN
            valid_all <= (cex_cnt == '0);
`else
            valid_all <= 1'b1;
`endif
            done      <= 1'b1;
            busy      <= 1'b0;
            r_state   <= S_DONE;
          end else begin
            r_idx   <= r_idx + 1'b1;
            r_state <= S_APPLY;
          end
        end
        S_REPORT: begin
          if (cex_valid && cex_ready) begin
            cex_valid <= 1'b0;
`ifdef FORMULA_ENUM_ALL_CEX_EN
            if (w_last) begin
              valid_all <= 1'b0;
              done      <= 1'b1;
              busy      <= 1'b0;
              r_state   <= S_DONE;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= S_APPLY;
            end
`else
            valid_all <= 1'b0;
            done      <= 1'b1;
            busy      <= 1'b0;
            r_state   <= S_DONE;
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_formula_enum_sequencer.sv
// Bench for formula_enum_sequencer: formula stub driven by a falsifying-index table, scoreboard of expected counterexamples.
module tb_formula_enum_sequencer;

  localparam int N_IN   = 49;
  localparam int K_MAX  = 8;
  localparam int SETTLE = 2;
  localparam int KW     = $clog2(K_MAX + 1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              cex_ready = 1'b0;
  logic [KW-1:0]     k_sel = '0;
  logic [N_IN-1:0]   base_vec = '0;
  logic [N_IN-1:0]   f_vec;
  logic [N_IN-1:0]   cex_vec;
  logic              f_out;
  logic              busy, done, valid_all, cex_valid;
  logic [K_MAX:0]    eval_cnt;
`ifdef FORMULA_ENUM_ALL_CEX_EN
  logic [K_MAX:0]    cex_cnt;
`endif
  logic [2:0]        dbg_state;

  logic [255:0]      bad_bits = '0;
  logic [7:0]        stub_mask = '0;
  logic [N_IN-1:0]   exp_q[$];
  int                n_checks = 0;
  int                n_errors = 0;

  formula_enum_sequencer #(.N_IN(N_IN), .K_MAX(K_MAX), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_sel(k_sel), .base_vec(base_vec),
    .f_vec(f_vec), .f_out(f_out), .busy(busy), .done(done), .valid_all(valid_all),
    .cex_valid(cex_valid), .cex_ready(cex_ready), .cex_vec(cex_vec), .eval_cnt(eval_cnt),
`ifdef FORMULA_ENUM_ALL_CEX_EN
    .cex_cnt(cex_cnt),
`endif
    .dbg_state(dbg_state)
  );

  // Formula stub: false exactly at the enumerated indices flagged in bad_bits.
  assign f_out = ~bad_bits[f_vec[7:0] & stub_mask];

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input int k, input logic [N_IN-1:0] base, input logic [255:0] bad,
                       output int e_eval, output logic e_valid,
                       output logic [N_IN-1:0] e_last, output int e_ncex);
    logic [N_IN-1:0] mask, v;
    mask = (N_IN'(1) << k) - N_IN'(1);
    e_eval = 0; e_ncex = 0; e_valid = 1'b1; e_last = '0;
    for (int i = 0; i < (1 << k); i++) begin
      v = (base & ~mask) | (N_IN'(i) & mask);
      e_eval++;
      e_last = v;
      if (bad[i]) begin
        exp_q.push_back(v);
        e_ncex++;
        e_valid = 1'b0;
`ifndef FORMULA_ENUM_ALL_CEX_EN
        break;
`endif
      end
    end
  endtask

  task automatic run_case(input string tag, input int ksel, input logic [N_IN-1:0] base,
                          input logic [255:0] bad, input int delay, input int busy_start_at);
    int k, e_eval, e_ncex, cyc, held;
    logic e_valid, seen;
    logic [N_IN-1:0] e_last;
    k = (ksel > K_MAX) ? K_MAX : ksel;
    exp_q.delete();
    model(k, base, bad, e_eval, e_valid, e_last, e_ncex);
    bad_bits  = bad;
    stub_mask = 8'((1 << k) - 1);
    @(negedge clk);
    k_sel = KW'(ksel); base_vec = base; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    k_sel = KW'($urandom_range(0, 15));
    base_vec = N_IN'({$urandom, $urandom});
    cyc = 0; held = 0; seen = 1'b0;
    while (!seen && cyc < 5000) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cex_ready) cex_ready = 1'b0;
      if (start) start = 1'b0;
      if (cyc == busy_start_at) start = 1'b1;
      if (cex_valid) begin
        if (exp_q.size() == 0) begin
          check({tag, "_cex_unexpected"}, 64'(cex_valid), 64'd0);
          cex_ready = 1'b1;
        end else begin
          check({tag, "_cex_vec"}, 64'(cex_vec), 64'(exp_q[0]));
          if (held >= delay) begin
            cex_ready = 1'b1;
            void'(exp_q.pop_front());
            held = 0;
          end else begin
            held++;
          end
        end
      end
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    check({tag, "_eval_cnt"}, 64'(eval_cnt), 64'(e_eval));
    check({tag, "_valid_all"}, 64'(valid_all), 64'(e_valid));
    check({tag, "_f_vec_last"}, 64'(f_vec), 64'(e_last));
    check({tag, "_cex_left"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_busy_low"}, 64'(busy), 64'd0);
    if (e_ncex == 0) check({tag, "_latency"}, 64'(cyc), 64'((1 << k) * (SETTLE + 2)));
`ifdef FORMULA_ENUM_ALL_CEX_EN
    check({tag, "_cex_cnt"}, 64'(cex_cnt), 64'(e_ncex));
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_f_vec"}, 64'(f_vec), 64'd0);
    check({tag, "_cex_vec"}, 64'(cex_vec), 64'd0);
    check({tag, "_eval_cnt"}, 64'(eval_cnt), 64'd0);
    check({tag, "_flags"}, {60'd0, busy, done, valid_all, cex_valid}, 64'd0);
    check({tag, "_state"}, 64'(dbg_state), 64'd0);
`ifdef FORMULA_ENUM_ALL_CEX_EN
    check({tag, "_cex_cnt"}, 64'(cex_cnt), 64'd0);
`endif
  endtask

  initial begin
    logic [255:0] bad;
    int cyc, k;
    // Clock/reset block
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    run_case("all_true_k3", 3, N_IN'({$urandom, $urandom}), '0, 0, 0);

    bad = '0; bad[5] = 1'b1;
    run_case("cex101_k3", 3, {N_IN{1'b1}}, bad, 5, 0);

    run_case("k0", 0, 49'h1_2345_6789_ABCD, '0, 0, 0);

    bad = '0; bad[1] = 1'b1; bad[6] = 1'b1;
    run_case("cex_1_6", 3, N_IN'({$urandom, $urandom}), bad, 2, 0);

    run_case("busy_start", 2, N_IN'({$urandom, $urandom}), '0, 0, 5);

    run_case("clamp", K_MAX + 3, N_IN'({$urandom, $urandom}), '0, 0, 0);

    // Reset while waiting on assignment 4
    bad_bits = '0; stub_mask = 8'h07;
    @(negedge clk);
    k_sel = KW'(3); base_vec = N_IN'({$urandom, $urandom}); start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    while (!(dbg_state == 3'd2 && f_vec[2:0] == 3'd4) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("mid_reset_reached", 64'(cyc < 200), 64'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("mid_reset");
    rst_n = 1'b1;
    bad = '0; bad[0] = 1'b1;
    run_case("restart_idx0", 3, N_IN'({$urandom, $urandom}), bad, 1, 0);

    for (int r = 0; r < 4; r++) begin
      k = $urandom_range(0, 5);
      bad = '0;
      for (int j = 0; j < (1 << k); j++) bad[j] = ($urandom_range(0, 6) == 0);
      run_case($sformatf("rand%0d", r), k, N_IN'({$urandom, $urandom}), bad,
               $urandom_range(0, 3), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
